// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the program counter and runs the fetch -> execute -> update loop.
//   An instruction is fetched over a req/ack handshake and latched for the decoder.
//   The sequencer then waits for execute completion and selects the next PC.
//   Next-PC priority is jmp > br_taken > pc+1. Branches take an unsigned magnitude
//   plus a direction bit. All arithmetic wraps modulo 2^WIDTH.
//   Compile-time option: defining PC_RAS_EN adds call/ret support backed by a
//   RAS_DEPTH-entry return-address stack. Priority then becomes
//   ret > call > jmp > br_taken > pc+1.
// Ports
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   imem_req/addr/ack/data       instruction fetch handshake (addr = pc)
//   instr_valid, instr           latched instruction presented to decode
//   exec_done, stall             execute completion / sequencer freeze
//   br_taken, br_decr, br_diff   PC-relative branch (direction + unsigned magnitude)
//   jmp, jmp_addr                absolute jump
//   call, ret, ras_err           return stack control / sticky error (PC_RAS_EN only)
//   pc                           current program counter
module pc_sequencer #(
  parameter int unsigned       WIDTH     = 16,
  parameter logic [WIDTH-1:0]  RESET_PC  = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  input  logic             exec_done,
  input  logic             stall,
  input  logic             br_taken,
  input  logic             br_decr,
  input  logic [WIDTH-1:0] br_diff,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_addr,
`ifdef PC_RAS_EN
  input  logic             call,
  input  logic             ret,
  output logic             ras_err,
`endif
  output logic [WIDTH-1:0] pc
);

  if (RAS_DEPTH == 0) begin : g_bad_ras_depth
    $error("pc_sequencer: RAS_DEPTH must be at least 1");
  end

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_UPDATE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_next_pc;
  logic             r_imem_req;
  logic             r_instr_valid;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_next_pc;
  logic             w_fetch_fire;
  logic             w_exec_fire;
  logic             w_update_fire;

`ifdef PC_RAS_EN
  localparam int unsigned RAS_CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0]  r_ras [RAS_DEPTH];   // index 0 is the most recent entry
  logic [RAS_CW-1:0] r_ras_cnt;
  logic              r_ras_err;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FETCH:  if (w_fetch_fire)  w_state_nxt = S_EXEC;
      S_EXEC:   if (w_exec_fire)   w_state_nxt = S_UPDATE;
      S_UPDATE: if (w_update_fire) w_state_nxt = S_FETCH;
      default:                     w_state_nxt = S_FETCH;
    endcase
  end

  // Per-state strobes. The fetch strobe is gated by the registered request so
  // an ack arriving in the idle cycle right after reset is ignored.
  always_comb begin
    w_fetch_fire  = (r_state == S_FETCH) && r_imem_req && imem_ack;
    w_exec_fire   = (r_state == S_EXEC) && exec_done && !stall;
    w_update_fire = (r_state == S_UPDATE) && !stall;
  end

  // Next-PC selection, evaluated while in S_EXEC and captured on exec completion
  always_comb begin
    w_pc_inc  = r_pc + ONE;
    w_next_pc = w_pc_inc;
`ifdef PC_RAS_EN
    if (ret)
      w_next_pc = (r_ras_cnt != '0) ? r_ras[0] : w_pc_inc;
    else if (call)
      w_next_pc = jmp_addr;
    else
`endif
    if (jmp)
      w_next_pc = jmp_addr;
    else if (br_taken)
      w_next_pc = br_decr ? (r_pc - br_diff) : (r_pc + br_diff);
  end

  // Datapath registers; imem_req is registered from the next state so it is
  // high for every cycle spent in S_FETCH except the first one after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_next_pc     <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
    end else begin
      r_imem_req <= (w_state_nxt == S_FETCH);
      if (w_fetch_fire) begin
        r_instr       <= imem_data;
        r_instr_valid <= 1'b1;
      end
      if (w_exec_fire) begin
        r_instr_valid <= 1'b0;
        r_next_pc     <= w_next_pc;
      end
      if (w_update_fire) r_pc <= r_next_pc;
    end
  end

`ifdef PC_RAS_EN
  // Return stack as a shift register: a push into a full stack shifts the
  // oldest entry out of the bottom.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ras_cnt <= '0;
      r_ras_err <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else if (w_exec_fire) begin
      if (ret) begin
        if (r_ras_cnt != '0) begin
          for (int unsigned i = 0; i + 1 < RAS_DEPTH; i++) r_ras[i] <= r_ras[i+1];
          r_ras_cnt <= r_ras_cnt - RAS_CW'(1);
        end else begin
          r_ras_err <= 1'b1;
        end
      end else if (call) begin
        for (int unsigned i = 1; i < RAS_DEPTH; i++) r_ras[i] <= r_ras[i-1];
        r_ras[0] <= w_pc_inc;
        if (r_ras_cnt == RAS_CW'(RAS_DEPTH)) r_ras_err <= 1'b1;
        else                                 r_ras_cnt <= r_ras_cnt + RAS_CW'(1);
      end
    end
  end

  assign ras_err = r_ras_err;
`endif

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign pc          = r_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
module tb_pc_sequencer;
  localparam int unsigned DEPTH  = 4;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset, imem_ack, exec_done, stall, br_taken, br_decr, jmp, call, ret;
  logic [15:0] imem_data, br_diff, jmp_addr;
  logic        imem_req, instr_valid;
  logic [15:0] imem_addr, instr, pc;
`ifdef PC_RAS_EN
  logic        ras_err;
`endif

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  int unsigned fetch_cyc = 0;

  // Reference model state: PC as an integer, return stack as a queue (front = newest)
  int   m_pc;
  int   ras_q[$];
  bit   m_err;

  typedef struct {
    bit          j;
    logic [15:0] ja;
    bit          b;
    bit          d;
    logic [15:0] df;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[13];

  pc_sequencer #(.WIDTH(16), .RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr(instr),
    .exec_done(exec_done), .stall(stall),
    .br_taken(br_taken), .br_decr(br_decr), .br_diff(br_diff),
    .jmp(jmp), .jmp_addr(jmp_addr),
`ifdef PC_RAS_EN
    .call(call), .ret(ret), .ras_err(ras_err),
`endif
    .pc(pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] mem(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Next PC computed from the rules with plain integer arithmetic mod 65536
  task automatic model_step(input bit j, input int ja, input bit b, input bit d,
                            input int df, input bit c, input bit r);
    int nxt;
    if (r) begin
      if (ras_q.size() > 0) nxt = ras_q.pop_front();
      else begin nxt = m_pc + 1; m_err = 1'b1; end
    end else if (c) begin
      ras_q.push_front((m_pc + 1) % 65536);
      if (ras_q.size() > DEPTH) begin void'(ras_q.pop_back()); m_err = 1'b1; end
      nxt = ja;
    end else if (j)  nxt = ja;
    else if (b)      nxt = d ? (m_pc + 65536 - df) : (m_pc + df);
    else             nxt = m_pc + 1;
    m_pc = nxt % 65536;
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ack = 0; exec_done = 0; stall = 0; br_taken = 0; br_decr = 0;
    jmp = 0; call = 0; ret = 0; br_diff = '0; jmp_addr = '0; imem_data = '0;
    repeat (3) @(negedge clk);
    chk("reset imem_req", imem_req, 0);
    chk("reset instr_valid", instr_valid, 0);
    chk("reset instr", instr, 0);
    chk("reset pc", pc, RST_PC);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset imem_req", imem_req, 1);
    chk("post-reset imem_addr", imem_addr, RST_PC);
    m_pc = RST_PC; ras_q.delete(); m_err = 1'b0;
  endtask

  // One full instruction: fetch (with optional ack delay), execute (with optional
  // delay/stall), update (with optional stall). Ends at the negedge where the
  // next fetch request should be visible.
  task automatic run_instr(input bit j, input logic [15:0] ja, input bit b, input bit d,
                           input logic [15:0] df, input bit c, input bit r,
                           input int ack_dly, input int exec_dly,
                           input int stall_exec, input int stall_upd, input string tag);
    int k;
    int prev;
    k = 0;
    while (imem_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (imem_req !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s fetch-timeout: imem_req=%b after 20 cycles, expected 1", tag, imem_req);
      return;
    end
    fetch_cyc = cyc;
    chk({tag, " fetch addr"}, imem_addr, m_pc);
    for (int i = 0; i < ack_dly; i++) begin
      stall = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk({tag, " req held"}, imem_req, 1);
      chk({tag, " addr held"}, imem_addr, m_pc);
      chk({tag, " valid low in fetch"}, instr_valid, 0);
    end
    stall = 1'($urandom_range(0, 1));
    imem_ack = 1'b1; imem_data = mem(16'(m_pc));
    @(negedge clk);
    imem_ack = 1'b0; imem_data = 16'($urandom); stall = 1'b0;
    chk({tag, " instr_valid"}, instr_valid, 1);
    chk({tag, " instr"}, instr, mem(16'(m_pc)));
    chk({tag, " req dropped"}, imem_req, 0);
    for (int i = 0; i < exec_dly; i++) begin
      @(negedge clk);
      chk({tag, " valid waiting exec"}, instr_valid, 1);
    end
    jmp = j; jmp_addr = ja; br_taken = b; br_decr = d; br_diff = df; call = c; ret = r;
    exec_done = 1'b1;
    if (stall_exec > 0) begin
      stall = 1'b1;
      for (int i = 0; i < stall_exec; i++) begin
        @(negedge clk);
        chk({tag, " exec not consumed"}, instr_valid, 1);
        chk({tag, " pc during exec stall"}, pc, m_pc);
      end
      stall = 1'b0;
    end
    @(negedge clk);
    exec_done = 1'b0;
    jmp = 1'($urandom); br_taken = 1'($urandom); br_decr = 1'($urandom);
    jmp_addr = 16'($urandom); br_diff = 16'($urandom); call = 0; ret = 0;
    prev = m_pc;
    model_step(j, int'(ja), b, d, int'(df), c, r);
    chk({tag, " valid cleared"}, instr_valid, 0);
    if (stall_upd > 0) begin
      stall = 1'b1;
      for (int i = 0; i < stall_upd; i++) begin
        @(negedge clk);
        chk({tag, " pc held in update"}, pc, prev);
        chk({tag, " req low in update"}, imem_req, 0);
      end
      stall = 1'b0;
    end
    @(negedge clk);
    chk({tag, " next req"}, imem_req, 1);
    chk({tag, " next pc"}, pc, m_pc);
  endtask

  initial begin
    int c_a;
    vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0004};
    vecs[1]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0010};
    vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0014, 16'hFFFC};
    vecs[3]  = '{1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0000, 16'hFFFE};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h0001};
    vecs[5]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 16'h0100, 16'h1234};
    vecs[6]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'hFFFF};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0002};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005, 16'hFFFD};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 16'hFFFE};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hFFFE};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF};

    do_reset();

    // Sequential fetch with same-cycle ack and immediate exec_done
    chk("seq addr0", imem_addr, 16'h0000);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "seq0");
    c_a = int'(fetch_cyc);
    chk("seq addr1", imem_addr, 16'h0001);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "seq1");
    chk("seq spacing", fetch_cyc - c_a, 3);
    chk("seq addr2", imem_addr, 16'h0002);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "seq2");

    foreach (vecs[i]) begin
      run_instr(vecs[i].j, vecs[i].ja, vecs[i].b, vecs[i].d, vecs[i].df, 0, 0,
                0, 0, 0, 0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d target", i), imem_addr, vecs[i].exp);
    end

    // Slow memory, stalled execute and stalled update
    run_instr(1, 16'h4000, 0, 0, 0, 0, 0, 5, 2, 3, 4, "stall");
    chk("stall target", imem_addr, 16'h4000);

    // Reset during fetch with a simultaneous ack, then a late ack after reset
    imem_ack = 1'b1; imem_data = 16'hBEEF; reset = 1'b1;
    @(negedge clk);
    chk("rst-fetch instr_valid", instr_valid, 0);
    chk("rst-fetch pc", pc, RST_PC);
    chk("rst-fetch imem_req", imem_req, 0);
    reset = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late-ack ignored", instr_valid, 0);
    chk("late-ack req", imem_req, 1);
    chk("late-ack addr", imem_addr, RST_PC);
    m_pc = RST_PC; ras_q.delete(); m_err = 1'b0;

`ifdef PC_RAS_EN
    for (int i = 1; i <= 5; i++) begin
      run_instr(0, 16'(i * 256), 0, 0, 0, 1, 0, 0, 0, 0, 0, $sformatf("call%0d", i));
      chk($sformatf("call%0d target", i), imem_addr, 16'(i * 256));
      chk($sformatf("call%0d ras_err", i), ras_err, (i == 5) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      run_instr(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, $sformatf("ret%0d", i));
      chk($sformatf("ret%0d target", i), imem_addr, 16'h0401 - 16'(i * 256));
    end
    run_instr(1, 16'h7777, 1, 0, 16'h0010, 1, 1, 0, 0, 0, 0, "ret-empty");
    chk("ret-empty target", imem_addr, 16'h0102);
    chk("ret-empty ras_err", ras_err, 1);
    do_reset();
    chk("ras_err after reset", ras_err, 0);
`endif

    // Randomized instruction stream against the reference model
    for (int n = 0; n < 150; n++) begin
      int unsigned sel;
      bit          j, b, d, c, r;
      logic [15:0] ja, df;
      sel = $urandom_range(0, 9);
      j = (sel <= 1); b = (sel >= 2 && sel <= 5) || ($urandom_range(0, 3) == 0);
      d = 1'($urandom); ja = 16'($urandom);
      df = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 8)) : 16'($urandom);
      c = 1'b0; r = 1'b0;
`ifdef PC_RAS_EN
      c = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 7) == 0);
`endif
      run_instr(j, ja, b, d, df, c, r, $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end
`ifdef PC_RAS_EN
    chk("rnd ras_err", ras_err, m_err);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
